avmm_mem_responder: RTL and testbench

Avalon-MM slave that answers the memory-port traffic our display pipeline issues (active-low `read_n`/`write_n`, `waitrequest`, pipelined `readdatavalid`). It is backed by on-chip block RAM. It replaces the external SDRAM controller during bring-up, and serves as the small on-chip voxel buffer on boards without SDRAM. The slave timing is deterministic so that the DVI-write / LED-read arbiter can be exercised cycle-accurately.

---
 rtl/avmm_mem_responder.sv | 153 +++++++++++++++
 tb/tb_avmm_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_mem_responder.sv
// avmm_mem_responder: Avalon-MM slave backed by on-chip block RAM.
// Active-low read_n/write_n, pipelined readdatavalid with a fixed
// READ_LATENCY, back-pressure from an outstanding-read limit and an
// optional periodic stall injector for arbiter bring-up.
module avmm_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 8,
  parameter int WAIT_PERIOD  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read_n,
  input  logic                    write_n,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH/8-1:0] byteenable_n,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic [3:0]              pending,
  output logic                    protocol_err
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // Storage and read path
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ramQ;
  logic [DATA_WIDTH-1:0]   dataPipeReg [1:READ_LATENCY-1];
  logic [READ_LATENCY-1:0] validPipeReg;

  // Control state
  logic       readyReg;
  logic [3:0] pendingReg;
  logic [3:0] pendingNext;
  logic [7:0] stallCntReg;
  logic       protocolErrReg;

  // Decoded command strobes
  logic                 stallNow;
  logic                 fullNow;
  logic                 acceptRead;
  logic                 acceptWrite;
  logic                 illegalCmd;
  logic [NUM_LANES-1:0] laneWe;

  // Back-pressure is derived from registers only, so a master may gate its
  // request on waitrequest combinationally without forming a loop.
  assign stallNow    = (WAIT_PERIOD != 0) && (stallCntReg == 8'(WAIT_PERIOD - 1));
  assign fullNow     = (pendingReg == 4'(MAX_PENDING));
  assign waitrequest = !readyReg || fullNow || stallNow;

  assign acceptRead  = !waitrequest && !read_n &&  write_n;
  assign acceptWrite = !waitrequest &&  read_n && !write_n;
  assign illegalCmd  = !waitrequest && !read_n && !write_n;

  // Per-lane write strobes (byteenable_n is active low)
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gLane
    assign laneWe[gi] = acceptWrite && !byteenable_n[gi];
  end

  // Byte-lane RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (laneWe[i]) begin
        mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

  // RAM read port sampled at acceptance, so a later write cannot alter a
  // read already in flight, and an earlier write is always visible.
  always_ff @(posedge clk) begin
    if (acceptRead) begin
      ramQ <= mem[address];
    end
  end

  // Valid pipeline: one bit per cycle of latency, cleared by reset so that
  // in-flight reads are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validPipeReg <= '0;
    end else begin
      validPipeReg <= {validPipeReg[READ_LATENCY-2:0], acceptRead};
    end
  end

  // Data pipeline; stages only load on a valid word, so the last stage
  // holds the previous return while readdatavalid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 1; s < READ_LATENCY; s++) begin
        dataPipeReg[s] <= '0;
      end
    end else begin
      if (validPipeReg[0]) begin
        dataPipeReg[1] <= ramQ;
      end
      for (int s = 2; s < READ_LATENCY; s++) begin
        if (validPipeReg[s-1]) begin
          dataPipeReg[s] <= dataPipeReg[s-1];
        end
      end
    end
  end

  assign readdatavalid = validPipeReg[READ_LATENCY-1];
  assign readdata      = dataPipeReg[READ_LATENCY-1];

  // Outstanding-read count: up on accept, down on return, flat on both
  always_comb begin
    pendingNext = pendingReg;
    case ({acceptRead, readdatavalid})
      2'b10:   pendingNext = pendingReg + 4'd1;
      2'b01:   pendingNext = pendingReg - 4'd1;
      default: pendingNext = pendingReg;
    endcase
  end

  // Control registers: ready flag, pending count, sticky protocol error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readyReg       <= 1'b0;
      pendingReg     <= 4'd0;
      protocolErrReg <= 1'b0;
    end else begin
      readyReg   <= 1'b1;
      pendingReg <= pendingNext;
      if (illegalCmd) begin
        protocolErrReg <= 1'b1;
      end
    end
  end

  // Free-running stall counter, wraps at WAIT_PERIOD-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCntReg <= 8'd0;
    end else if (stallCntReg == 8'(WAIT_PERIOD - 1)) begin
      stallCntReg <= 8'd0;
    end else begin
      stallCntReg <= stallCntReg + 8'd1;
    end
  end

  assign pending      = pendingReg;
  assign protocol_err = protocolErrReg;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// tb_avmm_mem_responder: scoreboard bench for two configurations of the
// responder (default, and MAX_PENDING=2 with WAIT_PERIOD=4). A reference
// model predicts back-pressure, pending count and read data; a monitor
// per instance matches every readdatavalid against the expected queue.
module tb_avmm_mem_responder;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk;
  int   nVec = 0;
  int   nErr = 0;
  bit   done [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One line per comparison failure
  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      if (nErr <= 40)
        $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : gInst
    localparam int MP  = (gi == 0) ? 8 : 2;
    localparam int WP  = (gi == 0) ? 0 : 4;
    localparam int LAT = 3;

    logic        rstS = 1'b1;
    logic        rdN, wrN;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  benN;
    logic [15:0] rdata;
    logic        rdv, wreq, perr;
    logic [3:0]  pend;

    avmm_mem_responder #(
      .ADDR_WIDTH(10), .DATA_WIDTH(16), .READ_LATENCY(LAT),
      .MAX_PENDING(MP), .WAIT_PERIOD(WP)
    ) dut (
      .clk(clk), .reset(rstS), .address(addr), .read_n(rdN), .write_n(wrN),
      .writedata(wdata), .byteenable_n(benN), .readdata(rdata),
      .readdatavalid(rdv), .waitrequest(wreq), .pending(pend), .protocol_err(perr)
    );

    // Reference model state
    int          edgeCnt;
    logic [15:0] mdl [1024];
    int          outT [$];
    exp_t        sbq [$];
    bit          mWait;
    bit          perrM;

    always @(posedge clk or posedge rstS) begin
      if (rstS) edgeCnt <= 0;
      else      edgeCnt <= edgeCnt + 1;
    end

    task automatic chkInReset();
      chk("rst_rdv", gi, rdv, 0);
      chk("rst_pending", gi, pend, 0);
      chk("rst_wait", gi, wreq, 1);
      chk("rst_perr", gi, perr, 0);
      chk("rst_rdata", gi, rdata, 0);
    endtask

    task automatic doReset();
      @(negedge clk);
      rstS = 1'b1; rdN = 1'b1; wrN = 1'b1;
      sbq.delete(); outT.delete(); perrM = 0;
      #1 chkInReset();
      repeat (3) @(posedge clk);
      #1 chkInReset();
      @(negedge clk);
      rstS = 1'b0;
      #1;
      mWait = 1;
      chk("wait_at_release", gi, wreq, 1);
    endtask

    // Drive one cycle, then advance the model by the edge that samples it
    task automatic step(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [15:0] d, input logic [1:0] ben, output bit acc);
      bit   w;
      int   e;
      exp_t ex;
      w = mWait;
      rdN = !rd; wrN = !wr; addr = a; wdata = d; benN = ben;
      @(posedge clk);
      #1;
      e   = edgeCnt;
      acc = !w;
      if (!w) begin
        if (rd && !wr) begin
          ex.data = mdl[a];
          ex.due  = e + LAT - 1;
          sbq.push_back(ex);
          outT.push_back(e);
        end else if (wr && !rd) begin
          for (int i = 0; i < 2; i++)
            if (!ben[i]) mdl[a][i*8 +: 8] = d[i*8 +: 8];
        end else if (rd && wr) begin
          perrM = 1;
        end
      end
      while (outT.size() > 0 && outT[0] + LAT <= e) void'(outT.pop_front());
      mWait = (e < 1) || (outT.size() == MP) || (WP != 0 && (e % WP) == WP - 1);
      chk("waitrequest", gi, wreq, mWait);
      chk("pending", gi, pend, outT.size());
      chk("protocol_err", gi, perr, perrM);
    endtask

    // Repeat a command until the slave takes it
    task automatic issue(input bit rd, input bit wr, input logic [9:0] a,
                         input logic [15:0] d, input logic [1:0] ben);
      bit acc;
      int n;
      n = 0;
      acc = 0;
      while (!acc && n < 50) begin
        step(rd, wr, a, d, ben, acc);
        n++;
      end
      if (!acc) chk("accept_timeout", gi, 0, 1);
    endtask

    task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(0, 0, 10'd0, 16'd0, 2'b11, acc);
    endtask

    // Stimulus
    initial begin : drv
      bit acc;
      int kind;
      rdN = 1'b1; wrN = 1'b1; addr = '0; wdata = '0; benN = '1;
      perrM = 0; mWait = 1;
      doReset();
      // burst write then back-to-back reads
      for (int i = 0; i < 8; i++) issue(0, 1, 10'(i), 16'(16'h1000 + i), 2'b00);
      for (int i = 0; i < 8; i++) issue(1, 0, 10'(i), 16'd0, 2'b00);
      idle(6);
      for (int i = 8; i < 32; i++) issue(0, 1, 10'(i), 16'($urandom), 2'b00);
      // byte lanes
      issue(0, 1, 10'h010, 16'hFFFF, 2'b00);
      issue(0, 1, 10'h010, 16'h1234, 2'b10);
      issue(1, 0, 10'h010, 16'd0, 2'b00);
      idle(6);
      // held-low reads over a long run
      for (int i = 0; i < 12; i++) issue(1, 0, 10'(i + 20), 16'd0, 2'b00);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
        kind = $urandom_range(0, 3);
        step(kind == 1 || kind == 2, kind == 3, 10'($urandom_range(0, 31)),
             16'($urandom), 2'($urandom_range(0, 3)), acc);
      end
      idle(8);
      // illegal command: no return, RAM unchanged, sticky error
      issue(1, 1, 10'd5, 16'hDEAD, 2'b00);
      idle(6);
      issue(1, 0, 10'd5, 16'd0, 2'b00);
      idle(6);
      // reset with reads in flight, then a normal read
      issue(1, 0, 10'd1, 16'd0, 2'b00);
      issue(1, 0, 10'd2, 16'd0, 2'b00);
      issue(1, 0, 10'd3, 16'd0, 2'b00);
      doReset();
      issue(1, 0, 10'd4, 16'd0, 2'b00);
      idle(8);
      chk("drain", gi, sbq.size(), 0);
      done[gi] = 1;
    end

    // Monitor: pop and compare on every returned word
    initial begin : mon
      logic [15:0] lastD;
      exp_t        ex;
      lastD = '0;
      forever begin
        @(posedge clk);
        #1;
        if (rstS) begin
          lastD = '0;
        end else if (rdv) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rdv", gi, 1, 0);
          end else begin
            ex = sbq.pop_front();
            chk("rdata", gi, rdata, ex.data);
            chk("rdv_cycle", gi, edgeCnt, ex.due);
          end
          lastD = rdata;
        end else begin
          chk("rdata_hold", gi, rdata, lastD);
        end
      end
    end
  end

  // Summary after both instances finish, bounded by a cycle budget
  initial begin : fin
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    #2;
    nVec++;
    if (!(done[0] && done[1])) begin
      nErr++;
      $display("FAIL watchdog: got unfinished expected finished");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
